regfile_n: RTL

Parametrised general-purpose register file for the datapath, successor to the fixed 8-bit register bank. It holds `NREG` registers of `W` bits each. Every register can be cleared, loaded, decremented or incremented under a write mask, and two registers are read combinationally on independent ports. It also provides per-register zero flags and a registered wrap/saturate event, which feed the ALU system's flag logic.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_cell.sv | 31 +++
 rtl/regfile_n.sv | 46 ++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared op encoding and build configuration (macro REGFILE_SAT_EN selects saturating inc/dec)
package regfile_pkg;
    typedef enum logic [1:0] {
        FS_CLR  = 2'b00,
        FS_LOAD = 2'b01,
        FS_DEC  = 2'b10,
        FS_INC  = 2'b11
    } funsel_t;
`ifdef REGFILE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
endpackage

// File: rtl/regfile_cell.sv
// regfile_cell: one W-bit register with clear/load/dec/inc, zero flag and wrap event (REGFILE_SAT_EN via regfile_pkg)
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  funsel_t      funsel,
    input  logic [W-1:0] load,
    output logic [W-1:0] value,
    output logic         zero,
    output logic         wrap_evt
);
    logic [W-1:0] nxt;
    assign zero     = value == '0;
    assign wrap_evt = en && ((funsel == FS_INC && &value) || (funsel == FS_DEC && zero));
    // next value for the selected op; a saturating build holds instead of wrapping
    always_comb begin
        nxt = (SAT_EN && wrap_evt) ? value :
              funsel == FS_CLR  ? '0 :
              funsel == FS_LOAD ? load :
              funsel == FS_DEC  ? value - 1'b1 : value + 1'b1;
    end
    // register state, updated only when this cell is in the write mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= '0;
        else if (en) value <= nxt;
    end
endmodule

// File: rtl/regfile_n.sv
// regfile_n: NREG x W register file with masked ops, two read ports, zero flags and wrap event (REGFILE_SAT_EN selects saturation)
module regfile_n
    import regfile_pkg::*;
#(
    parameter int W = 8,
    parameter int NREG = 8,
    localparam int SELW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    load,
    input  logic [1:0]      funsel,
    input  logic [NREG-1:0] wsel,
    input  logic [SELW-1:0] o1sel,
    input  logic [SELW-1:0] o2sel,
    output logic [W-1:0]    o1,
    output logic [W-1:0]    o2,
    output logic [NREG-1:0] zflag,
    output logic            wrap
);
    logic [W-1:0]    vals [2**SELW];
    logic [NREG-1:0] evts;
    for (genvar i = 0; i < 2**SELW; i++) begin : g_reg
        if (i < NREG) begin : g_cell
            regfile_cell #(.W(W)) u_cell (
                .clk      (clk),
                .rst      (rst),
                .en       (wsel[i]),
                .funsel   (funsel_t'(funsel)),
                .load     (load),
                .value    (vals[i]),
                .zero     (zflag[i]),
                .wrap_evt (evts[i])
            );
        end else begin : g_pad
            assign vals[i] = '0;
        end
    end
    assign o1 = vals[o1sel];
    assign o2 = vals[o2sel];
    // one-cycle event flag: any selected register wrapped or saturated on this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap <= 1'b0;
        else wrap <= |evts;
    end
endmodule
